// File: rtl/netbus_pkt_tx.sv
// NetBus source endpoint: frames a local byte stream into NetBus words with
// SOP/EOP/route control, enforces a maximum packet length, and drives the bus through a 2-entry skid buffer.
`timescale 1ns/1ps
module netbus_pkt_tx #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned MAX_WORDS  = 64,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [DATA_WIDTH*8-1:0]    s_data,
  input  logic [DATA_WIDTH-1:0]      s_keep,
  input  logic                       s_last,
  input  logic [7:0]                 s_route,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [DATA_WIDTH*9+13:0]   data,
  output logic                       valid,
  input  logic                       ready,
  output logic [CNT_WIDTH-1:0]       pkt_count,
  output logic [CNT_WIDTH-1:0]       trunc_count
);

  localparam int unsigned W    = DATA_WIDTH*9 + 14;
  localparam int unsigned BASE = DATA_WIDTH*9;
  localparam int unsigned WC_W = $clog2(MAX_WORDS + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PKT, ST_DRAIN} state_t;

  state_t            state, state_nxt;
  logic [WC_W-1:0]   wcnt, wcnt_nxt;
  logic [7:0]        route_q, route_nxt;
  logic [W-1:0]      skid_data, skid_data_nxt, data_nxt;
  logic              skid_valid, skid_valid_nxt, valid_nxt, s_ready_nxt;
  logic [CNT_WIDTH-1:0] pkt_count_nxt, trunc_count_nxt;

  logic [BASE-1:0]   lanes_c;
  logic [W-1:0]      word_c;
  logic              accept, emit, sop, eop, pop;
  logic [7:0]        word_route;

  // Lane packing: invalid lanes carry a zero byte and a cleared flag
  always_comb begin
    lanes_c = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      lanes_c[9*i +: 9] = s_keep[i] ? {1'b1, s_data[8*i +: 8]} : 9'd0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      wcnt        <= '0;
      route_q     <= '0;
      data        <= '0;
      valid       <= 1'b0;
      skid_data   <= '0;
      skid_valid  <= 1'b0;
      s_ready     <= 1'b0;
      pkt_count   <= '0;
      trunc_count <= '0;
    end else begin
      state       <= state_nxt;
      wcnt        <= wcnt_nxt;
      route_q     <= route_nxt;
      data        <= data_nxt;
      valid       <= valid_nxt;
      skid_data   <= skid_data_nxt;
      skid_valid  <= skid_valid_nxt;
      s_ready     <= s_ready_nxt;
      pkt_count   <= pkt_count_nxt;
      trunc_count <= trunc_count_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    wcnt_nxt        = wcnt;
    route_nxt       = route_q;
    trunc_count_nxt = trunc_count;
    pkt_count_nxt   = pkt_count;
    emit            = 1'b0;
    sop             = 1'b0;
    eop             = 1'b0;
    accept          = s_valid & s_ready;
    pop             = valid & ready;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          emit      = 1'b1;
          sop       = 1'b1;
          route_nxt = s_route;
          wcnt_nxt  = WC_W'(1);
          if (s_last) eop = 1'b1;
          else        state_nxt = ST_PKT;
        end
      end
      ST_PKT: begin
        if (accept) begin
          emit     = 1'b1;
          wcnt_nxt = wcnt + WC_W'(1);
          if (s_last) begin
            eop       = 1'b1;
            state_nxt = ST_IDLE;
          end else if (wcnt == WC_W'(MAX_WORDS - 1)) begin
            // Packet hit the length limit: close it here and swallow the rest
            eop             = 1'b1;
            trunc_count_nxt = trunc_count + CNT_WIDTH'(1);
            state_nxt       = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (accept && s_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    word_route = (state == ST_IDLE) ? s_route : route_q;
    word_c     = {word_route, 4'b0000, eop, sop, lanes_c};

    // Skid buffer: head register drives the bus, second entry absorbs one stall
    valid_nxt      = valid;
    data_nxt       = data;
    skid_valid_nxt = skid_valid;
    skid_data_nxt  = skid_data;
    if (!valid) begin
      if (emit) begin
        valid_nxt = 1'b1;
        data_nxt  = word_c;
      end
    end else if (pop) begin
      if (skid_valid) begin
        data_nxt = skid_data;
        if (emit) skid_data_nxt  = word_c;
        else      skid_valid_nxt = 1'b0;
      end else if (emit) begin
        data_nxt = word_c;
      end else begin
        valid_nxt = 1'b0;
      end
    end else if (emit) begin
      skid_valid_nxt = 1'b1;
      skid_data_nxt  = word_c;
    end

    if (pop && data[BASE+1]) pkt_count_nxt = pkt_count + CNT_WIDTH'(1);

    // Draining never writes the buffer, so input stays open regardless of fill
    s_ready_nxt = (state_nxt == ST_DRAIN) || !(valid_nxt && skid_valid_nxt);
  end

endmodule

// File: tb/tb_netbus_pkt_tx.sv
// Directed bench for netbus_pkt_tx (DATA_WIDTH=4, MAX_WORDS=4, CNT_WIDTH=4).
`timescale 1ns/1ps
module tb_netbus_pkt_tx;
  localparam int unsigned DW   = 4;
  localparam int unsigned MW   = 4;
  localparam int unsigned CW   = 4;
  localparam int unsigned W    = DW*9 + 14;
  localparam int unsigned BASE = DW*9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn = 1'b1;
  logic [DW*8-1:0] s_data = '0;
  logic [DW-1:0] s_keep = '0;
  logic          s_last = 1'b0;
  logic [7:0]    s_route = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [W-1:0]  data;
  logic          valid;
  logic          ready;
  logic [CW-1:0] pkt_count, trunc_count;

  logic ready_fixed = 1'b1;
  logic ready_rnd   = 1'b1;
  bit   rand_ready  = 1'b0;
  bit   mon_en      = 1'b0;
  assign ready = rand_ready ? ready_rnd : ready_fixed;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] outq[$];
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;

  netbus_pkt_tx #(.DATA_WIDTH(DW), .MAX_WORDS(MW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .resetn(resetn), .s_data(s_data), .s_keep(s_keep), .s_last(s_last),
    .s_route(s_route), .s_valid(s_valid), .s_ready(s_ready), .data(data), .valid(valid),
    .ready(ready), .pkt_count(pkt_count), .trunc_count(trunc_count)
  );

  always @(posedge clk) begin
    #1 ready_rnd = ($urandom_range(0, 99) >= 30);
  end

  // Output capture and bus-protocol watch, sampled mid-cycle
  always @(negedge clk) begin
    if (resetn) begin
      if (valid && ready) outq.push_back(data);
      if (mon_en) begin
        checks++;
        if (prev_stall && (valid !== 1'b1 || data !== prev_data)) begin
          errors++;
          $display("FAIL hold: valid=%b data=%h required valid=1 data=%h", valid, data, prev_data);
        end
        checks++;
        if (s_ready === 1'b0 && valid !== 1'b1) begin
          errors++;
          $display("FAIL s_ready_low: s_ready=0 with valid=%b required buffer occupied", valid);
        end
      end
      prev_stall = valid && !ready;
      prev_data  = data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  function automatic logic [W-1:0] mk_word(input logic [DW*8-1:0] d, input logic [DW-1:0] k,
                                           input logic sop, input logic eop, input logic [7:0] r);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < DW; i++) begin
      if (k[i]) w[9*i +: 9] = {1'b1, d[8*i +: 8]};
    end
    w[BASE]       = sop;
    w[BASE+1]     = eop;
    w[BASE+6 +: 8] = r;
    return w;
  endfunction

  task automatic do_reset();
    s_valid = 1'b0;
    resetn  = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;
    outq.delete();
  endtask

  task automatic send_beat(input logic [DW*8-1:0] d, input logic [DW-1:0] k,
                           input logic last, input logic [7:0] r);
    logic acc;
    int   cyc;
    s_data = d; s_keep = k; s_last = last; s_route = r; s_valid = 1'b1;
    acc = 1'b0;
    cyc = 0;
    while (!acc && cyc < 500) begin
      @(negedge clk); acc = s_ready;
      @(posedge clk); #1;
      cyc++;
    end
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: beat not accepted after %0d cycles, required acceptance", cyc);
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_words(input int n, input string name);
    int cyc;
    cyc = 0;
    while (outq.size() < n && cyc < 3000) begin
      @(negedge clk); cyc++;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (outq.size() != n) begin
      errors++;
      $display("FAIL %s_count: got %0d words required %0d", name, outq.size(), n);
    end
  endtask

  task automatic test_reset();
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (valid !== 1'b0 || data !== '0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b data=%h s_ready=%b required 0/0/0", valid, data, s_ready);
    end
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_sready_release: s_ready=%b required 0", s_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (s_ready !== 1'b1 || valid !== 1'b0 || pkt_count !== '0 || trunc_count !== '0) begin
      errors++;
      $display("FAIL reset_after: s_ready=%b valid=%b pkt=%0d trunc=%0d required 1/0/0/0",
               s_ready, valid, pkt_count, trunc_count);
    end
    outq.delete();
  endtask

  task automatic test_basic();
    logic [W-1:0] exp [3];
    do_reset();
    ready_fixed = 1'b1;
    send_beat(32'h03020100, 4'hF, 1'b0, 8'h5A);
    send_beat(32'h07060504, 4'hF, 1'b0, 8'hA5);
    send_beat(32'hDDCCBBAA, 4'h3, 1'b1, 8'h11);
    exp[0] = mk_word(32'h03020100, 4'hF, 1'b1, 1'b0, 8'h5A);
    exp[1] = mk_word(32'h07060504, 4'hF, 1'b0, 1'b0, 8'h5A);
    exp[2] = {8'h5A, 4'h0, 1'b1, 1'b0, 9'd0, 9'd0, 9'h1BB, 9'h1AA};
    wait_words(3, "basic");
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= outq.size() || outq[i] !== exp[i]) begin
        errors++;
        $display("FAIL basic_w%0d: got %h required %h", i, (i < outq.size()) ? outq[i] : '0, exp[i]);
      end
    end
    checks++;
    if (pkt_count !== 4'd1) begin
      errors++;
      $display("FAIL basic_pkt_count: got %0d required 1", pkt_count);
    end
  endtask

  task automatic test_single();
    logic [W-1:0] exp;
    do_reset();
    ready_fixed = 1'b1;
    exp = {8'h3C, 4'h0, 1'b1, 1'b1, 9'd0, 9'd0, 9'd0, 9'h144};
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: valid=%b required 0", valid);
    end
    s_data = 32'h11223344; s_keep = 4'h1; s_last = 1'b1; s_route = 8'h3C; s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    checks++;
    if (valid !== 1'b1 || data !== exp) begin
      errors++;
      $display("FAIL single_latency: valid=%b data=%h required 1 %h", valid, data, exp);
    end
    wait_words(1, "single");
  endtask

  task automatic test_trunc();
    logic [W-1:0] exp [6];
    logic [DW*8-1:0] d;
    do_reset();
    ready_fixed = 1'b1;
    for (int j = 0; j < 6; j++) begin
      d = {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)};
      if (j < 4) exp[j] = mk_word(d, 4'hF, j == 0, j == 3, 8'h77);
      send_beat(d, 4'hF, j == 5, 8'h77);
    end
    send_beat(32'hCAFEF00D, 4'hF, 1'b0, 8'h21);
    send_beat(32'h000000EE, 4'h1, 1'b1, 8'h21);
    exp[4] = mk_word(32'hCAFEF00D, 4'hF, 1'b1, 1'b0, 8'h21);
    exp[5] = mk_word(32'h000000EE, 4'h1, 1'b0, 1'b1, 8'h21);
    wait_words(6, "trunc");
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= outq.size() || outq[i] !== exp[i]) begin
        errors++;
        $display("FAIL trunc_w%0d: got %h required %h", i, (i < outq.size()) ? outq[i] : '0, exp[i]);
      end
    end
    checks++;
    if (trunc_count !== 4'd1 || pkt_count !== 4'd2) begin
      errors++;
      $display("FAIL trunc_counts: trunc=%0d pkt=%0d required 1/2", trunc_count, pkt_count);
    end
  endtask

  task automatic test_boundary();
    logic [W-1:0] exp [4];
    do_reset();
    ready_fixed = 1'b1;
    for (int j = 0; j < 4; j++) begin
      exp[j] = mk_word(32'h55AA55AA, (j == 3) ? 4'h0 : 4'hF, j == 0, j == 3, 8'h9C);
      send_beat(32'h55AA55AA, (j == 3) ? 4'h0 : 4'hF, j == 3, 8'h9C);
    end
    wait_words(4, "boundary");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= outq.size() || outq[i] !== exp[i]) begin
        errors++;
        $display("FAIL boundary_w%0d: got %h required %h", i, (i < outq.size()) ? outq[i] : '0, exp[i]);
      end
    end
    checks++;
    if (trunc_count !== 4'd0 || pkt_count !== 4'd1) begin
      errors++;
      $display("FAIL boundary_counts: trunc=%0d pkt=%0d required 0/1", trunc_count, pkt_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] expq[$];
    int exp_pkts, exp_trunc, len, errs_before;
    logic [7:0] r0;
    logic [DW*8-1:0] d;
    logic [DW-1:0] k;
    logic last;
    do_reset();
    exp_pkts = 0; exp_trunc = 0;
    rand_ready = 1'b1;
    mon_en = 1'b1;
    for (int p = 0; p < 100; p++) begin
      len = $urandom_range(1, 6);
      r0  = 8'($urandom);
      for (int b = 0; b < len; b++) begin
        d    = $urandom;
        k    = 4'((1 << $urandom_range(0, 4)) - 1);
        last = (b == len - 1);
        if (b < MW) expq.push_back(mk_word(d, k, b == 0, last || (b == MW - 1), r0));
        send_beat(d, k, last, (b == 0) ? r0 : 8'($urandom));
      end
      exp_pkts++;
      if (len > MW) exp_trunc++;
    end
    wait_words(expq.size(), "b2b");
    mon_en = 1'b0;
    rand_ready = 1'b0;
    errs_before = errors;
    for (int i = 0; i < expq.size(); i++) begin
      checks++;
      if (i >= outq.size() || outq[i] !== expq[i]) begin
        errors++;
        if (errors - errs_before < 5)
          $display("FAIL b2b_w%0d: got %h required %h", i, (i < outq.size()) ? outq[i] : '0, expq[i]);
      end
    end
    checks++;
    if (pkt_count !== CW'(exp_pkts) || trunc_count !== CW'(exp_trunc)) begin
      errors++;
      $display("FAIL b2b_counts: pkt=%0d trunc=%0d required %0d/%0d",
               pkt_count, trunc_count, CW'(exp_pkts), CW'(exp_trunc));
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] exp;
    do_reset();
    ready_fixed = 1'b0;
    send_beat(32'h01010101, 4'hF, 1'b0, 8'h66);
    send_beat(32'h02020202, 4'hF, 1'b0, 8'h66);
    checks++;
    if (s_ready !== 1'b0 || valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_full: s_ready=%b valid=%b required 0/1", s_ready, valid);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (valid !== 1'b0 || data !== '0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b data=%h s_ready=%b required 0/0/0", valid, data, s_ready);
    end
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    ready_fixed = 1'b1;
    @(posedge clk); #1;
    outq.delete();
    checks++;
    if (pkt_count !== '0 || trunc_count !== '0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_after: pkt=%0d trunc=%0d valid=%b required 0/0/0", pkt_count, trunc_count, valid);
    end
    exp = mk_word(32'hA1B2C3D4, 4'hF, 1'b1, 1'b1, 8'h42);
    send_beat(32'hA1B2C3D4, 4'hF, 1'b1, 8'h42);
    wait_words(1, "mid");
    checks++;
    if (outq.size() < 1 || outq[0] !== exp) begin
      errors++;
      $display("FAIL mid_first: got %h required %h", (outq.size() > 0) ? outq[0] : '0, exp);
    end
  endtask

  task automatic test_wrap();
    time t0;
    do_reset();
    ready_fixed = 1'b1;
    t0 = $time;
    for (int i = 0; i < 17; i++) send_beat(32'(i), 4'hF, 1'b1, 8'h01);
    checks++;
    if ($time - t0 != 170) begin
      errors++;
      $display("FAIL wrap_throughput: took %0t required 170", $time - t0);
    end
    wait_words(17, "wrap");
    checks++;
    if (pkt_count !== 4'd1) begin
      errors++;
      $display("FAIL wrap_pkt_count: got %0d required 1", pkt_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_trunc();
    test_boundary();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
